// File: rtl/lane_traffic_gen.sv
// Obstacle-lane generator: seeds NROWS lanes from a 16-bit LFSR, then moves each lane on tick.
// Define LANE_DIR_FLIP_EN to toggle a lane's direction on every 16th move of that lane.
module lane_traffic_gen #(
    parameter int               NROWS         = 16,
    parameter int               NCOLS         = 16,
    parameter int               MAX_OBJS      = 4,
    parameter logic [NROWS-1:0] RESERVED_MASK = 16'h8003,
    parameter logic [15:0]      SEED          = 16'h1ACE,
    parameter int               CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        hit,
    input  logic [1:0]                  level,
    input  logic                        stream_mode,
    output logic [NROWS-1:0][NCOLS-1:0] grid,
    output logic [NROWS-1:0]            row_moved,
    output logic                        ready
);
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;

    typedef enum logic [1:0] {INIT_CFG, INIT_OBJ, RUN} state_t;

    state_t                      r_state, w_state_nxt;
    logic [RW-1:0]               r_row;
    logic [2:0]                  r_k, r_nobj;
    logic [15:0]                 r_lfsr;
    logic [NROWS-1:0][NCOLS-1:0] r_mask;
    logic [NROWS-1:0][CNT_W-1:0] r_cnt;
    logic [NROWS-1:0][1:0]       r_spd;
    logic [NROWS-1:0]            r_dir, r_moved;
`ifdef LANE_DIR_FLIP_EN
    logic [NROWS-1:0][3:0]       r_moves;
`endif

    logic                        w_step, w_last_obj, w_last_row, w_place;
    logic [15:0]                 w_lfsr_nxt;
    logic [1:0]                  w_len;
    logic [3:0]                  w_col;
    logic [NCOLS-1:0]            w_run, w_obj;
    logic [NROWS-1:0]            w_edge, w_block, w_entry;
    logic [NROWS-1:0][NCOLS-1:0] w_shift;

    function automatic logic [CNT_W-1:0] reload(input logic [1:0] s, input logic [1:0] lv);
        logic [3:0] base;
        base = 4'b0001 << s;
        return CNT_W'(base >> lv);
    endfunction

    assign w_step     = (r_state == RUN) && tick && !hit;
    assign w_last_obj = (r_k == 3'(MAX_OBJS - 1));
    assign w_last_row = (r_row == RW'(NROWS - 1));
    assign w_place    = (r_k < r_nobj) && !RESERVED_MASK[r_row];
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Car of w_len cells starting at column w_col from the MSB: MSB-aligned run, rotated right.
    assign w_len = r_lfsr[9] ? 2'd3 : (r_lfsr[8] ? 2'd2 : 2'd1);
    assign w_col = 4'(r_lfsr[7:4] % NCOLS);
    assign w_run = ~({NCOLS{1'b1}} >> w_len);
    assign w_obj = NCOLS'({w_run, w_run} >> w_col);

    assign grid      = (r_state == RUN) ? r_mask : '0;
    assign row_moved = r_moved;
    assign ready     = (r_state == RUN);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT_CFG: w_state_nxt = INIT_OBJ;
            INIT_OBJ: if (w_last_obj) w_state_nxt = w_last_row ? RUN : INIT_CFG;
            RUN:      w_state_nxt = RUN;
            default:  w_state_nxt = INIT_CFG;
        endcase
    end

    // Entry cell: wrapped-around edge bit, or an LFSR spawn suppressed by the 0-1-1 neighbour pattern.
    always_comb begin
        w_edge  = '0;
        w_block = '0;
        w_entry = '0;
        w_shift = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (r_dir[r]) begin
                w_edge[r]  = r_mask[r][NCOLS-1];
                w_block[r] = ~r_mask[r][0] & r_mask[r][1] & 1'(r_mask[r] >> 2);
            end else begin
                w_edge[r]  = r_mask[r][0];
                w_block[r] = ~r_mask[r][NCOLS-1] & r_mask[r][NCOLS-2]
                           & 1'({r_mask[r], 1'b0} >> (NCOLS - 2));
            end
            w_entry[r] = stream_mode ? (r_lfsr[r % 16] & r_lfsr[(r + 5) % 16] & ~w_block[r])
                                     : w_edge[r];
            w_shift[r] = r_dir[r] ? {r_mask[r][NCOLS-2:0], w_entry[r]}
                                  : {w_entry[r], r_mask[r][NCOLS-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT_CFG;
            r_row   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT_CFG) begin
                r_k <= '0;
            end else if (r_state == INIT_OBJ) begin
                r_k <= r_k + 3'd1;
                if (w_last_obj) begin
                    r_k <= '0;
                    if (!w_last_row) r_row <= r_row + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr  <= SEED;
            r_nobj  <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_spd   <= '0;
            r_dir   <= '1;
            r_moved <= '0;
`ifdef LANE_DIR_FLIP_EN
            r_moves <= '0;
`endif
        end else begin
            r_moved <= '0;
            if (r_state != RUN || w_step) r_lfsr <= w_lfsr_nxt;
            case (r_state)
                INIT_CFG: begin
                    r_dir[r_row]  <= r_lfsr[0];
                    r_spd[r_row]  <= r_lfsr[3:2];
                    r_nobj        <= (r_lfsr[6:4] > 3'(MAX_OBJS)) ? 3'(MAX_OBJS) : r_lfsr[6:4];
                    r_mask[r_row] <= '0;
`ifdef LANE_DIR_FLIP_EN
                    r_moves[r_row] <= '0;
`endif
                end
                INIT_OBJ: begin
                    if (w_place) r_mask[r_row] <= r_mask[r_row] | w_obj;
                    if (w_last_obj && !RESERVED_MASK[r_row])
                        r_cnt[r_row] <= reload(r_spd[r_row], level);
                end
                RUN: begin
                    if (w_step) begin
                        for (int r = 0; r < NROWS; r++) begin
                            if (!RESERVED_MASK[r]) begin
                                if (r_cnt[r] == '0) begin
                                    r_mask[r]  <= w_shift[r];
                                    r_cnt[r]   <= reload(r_spd[r], level);
                                    r_moved[r] <= 1'b1;
`ifdef LANE_DIR_FLIP_EN
                                    r_moves[r] <= r_moves[r] + 4'd1;
                                    if (r_moves[r] == 4'hF) r_dir[r] <= ~r_dir[r];
`endif
                                end else begin
                                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
